// File: rtl/led_driver_pkg.sv
// rtl/led_driver_pkg.sv - shared state encoding, default timing and width helper for the strip driver
package led_driver_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        SEND     = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int DEF_NUM_STRIPS       = 4;
    localparam int DEF_CHANNEL_WIDTH    = 8;
    localparam int DEF_CHANNELS_PER_LED = 3;
    localparam int DEF_MAX_LEDS         = 200;
    localparam int DEF_ADDRESS_WIDTH    = 13;
    localparam int DEF_MEM_LATENCY      = 2;
    localparam int DEF_T_TOTAL          = 70;
    localparam int DEF_T_ZERO           = 20;
    localparam int DEF_T_ONE            = 50;
    localparam int DEF_T_RESET          = 50000;

    // Bits needed to hold every value 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/led_bit_timer.sv
// rtl/led_bit_timer.sv - bit period counter and MSB-first bit index with bit/byte boundary strobes
module led_bit_timer
    import led_driver_pkg::*;
#(
    parameter int T_TOTAL       = DEF_T_TOTAL,
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    localparam int BIT_W        = cnt_width(T_TOTAL - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             bit_start,
    output logic             bit_end,
    output logic             byte_start,
    output logic             byte_end
);

    localparam int IDX_W = cnt_width(CHANNEL_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(T_TOTAL - 1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(CHANNEL_WIDTH - 1);

    logic [IDX_W-1:0] bit_idx;

    // While stopped the timer parks on bit 0 of the MSB so a new byte starts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (!run) begin
            bit_cnt <= '0;
            bit_idx <= IDX_MSB;
        end else if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= (bit_idx == '0) ? IDX_MSB : bit_idx - IDX_W'(1);
        end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

    assign bit_start  = run && (bit_cnt == '0);
    assign bit_end    = run && (bit_cnt == BIT_LAST);
    assign byte_start = bit_start && (bit_idx == IDX_MSB);
    assign byte_end   = bit_end && (bit_idx == '0);

endmodule

// File: rtl/multi_strip_driver.sv
// rtl/multi_strip_driver.sv - drives NUM_STRIPS WS2812-style strips in parallel from a wide framebuffer port
module multi_strip_driver
    import led_driver_pkg::*;
#(
    parameter int NUM_STRIPS       = DEF_NUM_STRIPS,
    parameter int CHANNEL_WIDTH    = DEF_CHANNEL_WIDTH,
    parameter int CHANNELS_PER_LED = DEF_CHANNELS_PER_LED,
    parameter int MAX_LEDS         = DEF_MAX_LEDS,
    parameter int ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
    parameter int BASE_ADDRESS     = 0,
    parameter int MEM_LATENCY      = DEF_MEM_LATENCY,
    parameter int T_TOTAL          = DEF_T_TOTAL,
    parameter int T_ZERO           = DEF_T_ZERO,
    parameter int T_ONE            = DEF_T_ONE,
    parameter int T_RESET          = DEF_T_RESET
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                continuous,
    input  logic [$clog2(MAX_LEDS+1)-1:0]       num_leds,
    input  logic [NUM_STRIPS-1:0]               strip_enable,
    output logic [ADDRESS_WIDTH-1:0]            mem_addr,
    output logic                                mem_read_enable,
    input  logic [NUM_STRIPS*CHANNEL_WIDTH-1:0] mem_data,
    output logic [NUM_STRIPS-1:0]               strip_out,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int LED_W  = $clog2(MAX_LEDS + 1);
    localparam int BYTE_W = cnt_width(MAX_LEDS * CHANNELS_PER_LED + 1);
    localparam int BIT_W  = cnt_width(T_TOTAL - 1);
    localparam int CAP_W  = cnt_width(MEM_LATENCY);
    localparam int RST_W  = cnt_width(T_RESET - 1);

    localparam logic [LED_W-1:0]         LED_MAX   = LED_W'(MAX_LEDS);
    localparam logic [BIT_W-1:0]         HIGH_ONE  = BIT_W'(T_ONE);
    localparam logic [BIT_W-1:0]         HIGH_ZERO = BIT_W'(T_ZERO);
    localparam logic [RST_W-1:0]         RST_LAST  = RST_W'(T_RESET - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(BASE_ADDRESS);

    state_t state, next_state;

    logic [BIT_W-1:0]  bit_cnt;
    logic              bit_start, bit_end, byte_start, byte_end;
    logic [BYTE_W-1:0] total_bytes, byte_cnt;
    logic [CAP_W-1:0]  cap_cnt;
    logic [RST_W-1:0]  latch_cnt;
    logic [NUM_STRIPS-1:0] en_q;
    logic [NUM_STRIPS-1:0][CHANNEL_WIDTH-1:0] staging, shift_q;
    logic [LED_W-1:0]  leds_clamped;
    logic cap_now, last_byte, more_reads, latch_done, frame_start, enter_latch;

    led_bit_timer #(
        .T_TOTAL       (T_TOTAL),
        .CHANNEL_WIDTH (CHANNEL_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (state == SEND),
        .bit_cnt    (bit_cnt),
        .bit_start  (bit_start),
        .bit_end    (bit_end),
        .byte_start (byte_start),
        .byte_end   (byte_end)
    );

    assign leds_clamped = (num_leds > LED_MAX) ? LED_MAX : num_leds;
    assign cap_now      = (cap_cnt == CAP_W'(1));
    assign last_byte    = (byte_cnt + BYTE_W'(1) == total_bytes);
    assign more_reads   = (byte_cnt + BYTE_W'(1) < total_bytes);
    assign latch_done   = (latch_cnt == RST_LAST);
    assign frame_start  = (next_state == PREFETCH) && (state != PREFETCH);
    assign enter_latch  = (next_state == LATCH) && (state != LATCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start || continuous) next_state = PREFETCH;
            PREFETCH: if (cap_now) next_state = (total_bytes == '0) ? LATCH : SEND;
            SEND:     if (byte_end && last_byte) next_state = LATCH;
            LATCH:    if (latch_done) next_state = continuous ? PREFETCH : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Byte 0 is read on PREFETCH entry (no capture pending yet); byte k+1 at the start of byte k.
    always_comb begin
        busy            = (state != IDLE);
        frame_done      = (state == LATCH) && latch_done;
        mem_read_enable = ((state == PREFETCH) && (cap_cnt == '0)) ||
                          ((state == SEND) && byte_start && more_reads);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_bytes <= '0;
            en_q        <= '0;
            byte_cnt    <= '0;
            cap_cnt     <= '0;
            mem_addr    <= BASE;
            staging     <= '0;
            shift_q     <= '0;
            latch_cnt   <= '0;
            strip_out   <= '0;
        end else begin
            if (frame_start) begin
                total_bytes <= BYTE_W'(leds_clamped) * BYTE_W'(CHANNELS_PER_LED);
                en_q        <= strip_enable;
                byte_cnt    <= '0;
            end else if ((state == SEND) && byte_end) begin
                byte_cnt <= byte_cnt + BYTE_W'(1);
            end

            if (mem_read_enable) begin
                cap_cnt <= CAP_W'(MEM_LATENCY);
            end else if (cap_cnt != '0) begin
                cap_cnt <= cap_cnt - CAP_W'(1);
            end

            // Address is held until its data is captured, then steps to the next byte.
            if (enter_latch) begin
                mem_addr <= BASE;
            end else if (cap_now) begin
                mem_addr <= mem_addr + ADDRESS_WIDTH'(1);
            end

            if (cap_now) begin
                staging <= mem_data;
            end

            // Byte 0 has no earlier byte boundary, so it goes straight from the bus into the lanes.
            if ((state == PREFETCH) && cap_now) begin
                shift_q <= mem_data;
            end else if ((state == SEND) && byte_end) begin
                shift_q <= staging;
            end else if ((state == SEND) && bit_end) begin
                for (int s = 0; s < NUM_STRIPS; s++) begin
                    shift_q[s] <= shift_q[s] << 1;
                end
            end

            if ((state == LATCH) && !latch_done) begin
                latch_cnt <= latch_cnt + RST_W'(1);
            end else begin
                latch_cnt <= '0;
            end

            for (int s = 0; s < NUM_STRIPS; s++) begin
                strip_out[s] <= (state == SEND) && en_q[s] &&
                                (bit_cnt < (shift_q[s][CHANNEL_WIDTH-1] ? HIGH_ONE : HIGH_ZERO));
            end
        end
    end

endmodule
